// File: rtl/pulse_stretcher_pkg.sv
// Shared state encoding and cycle arithmetic for pulse_stretcher.
package pulse_stretcher_pkg;

    typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

    localparam longint unsigned NS_PER_MS = 64'd1_000_000;

    // Rounds up so a pulse is never shorter than the requested time.
    function automatic int unsigned cycles_from_ms(input int unsigned ms,
                                                   input int unsigned period_ns);
        longint unsigned total_ns;
        total_ns = 64'(ms) * NS_PER_MS;
        return 32'((total_ns + 64'(period_ns) - 64'd1) / 64'(period_ns));
    endfunction

endpackage

// File: rtl/interval_timer.sv
// Cycle counter with a runtime-selected terminal count; done marks the last cycle.
module interval_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] terminal,
    output logic             done
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_in) begin
        if (!rst_in || clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end

    assign done = (cnt_q == terminal);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches one-cycle event strobes into pulses with guaranteed high time and low gap.
// Define PULSE_STRETCHER_QUEUE_EN to replay events that arrive mid-pulse from a backlog.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int unsigned CLK_PERIOD_NS = 10,
    parameter int unsigned HIGH_TIME_MS  = 5,
    parameter int unsigned LOW_TIME_MS   = 5,
    parameter int unsigned MAX_PENDING   = 15,
    localparam int unsigned PEND_W       = $clog2(MAX_PENDING + 1)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              event_in,
    output logic              pulse_out,
    output logic              busy_out,
    output logic [PEND_W-1:0] pending_out,
    output logic              overflow_out
);

    localparam int unsigned HIGH_CYCLES = cycles_from_ms(HIGH_TIME_MS, CLK_PERIOD_NS);
    localparam int unsigned LOW_CYCLES  = cycles_from_ms(LOW_TIME_MS, CLK_PERIOD_NS);
    localparam int unsigned MAX_CYCLES  = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int unsigned CNT_W       = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(LOW_CYCLES - 1);

    state_t           state_q, state_d;
    logic             pulse_q, busy_q, overflow_q;
    logic             timer_clear, timer_enable, timer_done;
    logic [CNT_W-1:0] terminal;
    logic             gap_end, restart, overflow_set;

    assign gap_end      = (state_q == GAP) && timer_done;
    assign terminal     = (state_q == HIGH) ? HIGH_LAST : LOW_LAST;
    assign timer_enable = (state_q != IDLE);
    assign timer_clear  = (state_d != state_q);

    interval_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .clear    (timer_clear),
        .enable   (timer_enable),
        .terminal (terminal),
        .done     (timer_done)
    );

`ifdef PULSE_STRETCHER_QUEUE_EN
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              inc, dec;

    assign restart = event_in || (pending_q != '0);
    assign inc     = event_in && (state_q != IDLE);
    assign dec     = gap_end && restart;

    // An event landing on the gap-end cycle with an empty backlog nets to zero here.
    always_comb begin
        pending_d    = pending_q;
        overflow_set = 1'b0;
        if (inc && !dec) begin
            if (pending_q == PEND_W'(MAX_PENDING)) begin
                overflow_set = 1'b1;
            end else begin
                pending_d = pending_q + PEND_W'(1);
            end
        end else if (dec && !inc) begin
            pending_d = pending_q - PEND_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_out = pending_q;
`else
    // Without a backlog only a gap-end event is accepted while busy.
    assign restart      = event_in;
    assign overflow_set = event_in && (state_q != IDLE) && !gap_end;
    assign pending_out  = '0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (event_in) state_d = HIGH;
            HIGH:    if (timer_done) state_d = GAP;
            GAP:     if (gap_end) state_d = restart ? HIGH : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q    <= IDLE;
            pulse_q    <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pulse_q <= (state_d == HIGH);
            busy_q  <= (state_d != IDLE);
            if (overflow_set) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign pulse_out    = pulse_q;
    assign busy_out     = busy_q;
    assign overflow_out = overflow_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed plus random bench for pulse_stretcher against a window-based reference model.
module tb_pulse_stretcher;

    localparam int H_CYC = 3;  // ceil(3 ms / 1 ms)
    localparam int L_CYC = 2;  // ceil(2 ms / 1 ms)
    localparam int MAXP  = 3;
`ifdef PULSE_STRETCHER_QUEUE_EN
    localparam bit QUEUE_EN = 1'b1;
`else
    localparam bit QUEUE_EN = 1'b0;
`endif

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b0;
    logic       event_in = 1'b0;
    logic       pulse_out, busy_out, overflow_out;
    logic [1:0] pending_out;

    pulse_stretcher #(
        .CLK_PERIOD_NS (1_000_000),
        .HIGH_TIME_MS  (3),
        .LOW_TIME_MS   (2),
        .MAX_PENDING   (MAXP)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .event_in     (event_in),
        .pulse_out    (pulse_out),
        .busy_out     (busy_out),
        .pending_out  (pending_out),
        .overflow_out (overflow_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int failures = 0;

    // Model: a pulse window of H_CYC high + L_CYC low cycles starting at edge 'start'.
    int e = 0;
    int start = 0;
    int pend = 0;
    bit active = 1'b0;
    bit ovf = 1'b0;
    bit m_pulse, m_busy;
    int rises = 0;
    int max_pend = 0;
    logic prev_pulse = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit ev, input bit rst_n);
        bit at_end, restart;
        e++;
        if (!rst_n) begin
            active = 1'b0;
            pend   = 0;
            ovf    = 1'b0;
        end else if (!active) begin
            if (ev) begin
                active = 1'b1;
                start  = e;
            end
        end else begin
            at_end  = ((e - 1 - start) == H_CYC + L_CYC - 1);
            restart = ev || (QUEUE_EN && pend > 0);
            if (at_end && restart) begin
                start = e;
                if (QUEUE_EN && !ev) pend--;
            end else if (at_end) begin
                active = 1'b0;
            end else if (ev) begin
                if (!QUEUE_EN || pend == MAXP) ovf = 1'b1;
                else pend++;
            end
        end
        m_pulse = active && ((e - start) < H_CYC);
        m_busy  = active;
    endtask

    task automatic step(input bit ev, input bit rst_n);
        event_in = ev;
        rst_in   = rst_n;
        @(posedge clk_in);
        model_edge(ev, rst_n);
        #1;
        check("pulse_out", 32'(pulse_out), 32'(m_pulse));
        check("busy_out", 32'(busy_out), 32'(m_busy));
        check("pending_out", 32'(pending_out), pend);
        check("overflow_out", 32'(overflow_out), 32'(ovf));
        if (pulse_out === 1'b1 && prev_pulse !== 1'b1) rises++;
        if (int'(pending_out) > max_pend) max_pend = int'(pending_out);
        prev_pulse = pulse_out;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1);
    endtask

    initial begin
        // Reset, with a stray event that must be ignored
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        idle(6);

        // Single isolated event
        rises = 0;
        step(1'b1, 1'b1);
        idle(12);
        check("single_rises", rises, 1);

        // Trigger plus three events during HIGH
        rises = 0;
        max_pend = 0;
        step(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        idle(30);
        check("burst3_rises", rises, QUEUE_EN ? 4 : 1);
        check("burst3_max_pend", max_pend, QUEUE_EN ? 3 : 0);
        check("burst3_no_ovf", 32'(overflow_out), QUEUE_EN ? 0 : 1);
        step(1'b0, 1'b0);

        // Five consecutive events: backlog saturates
        rises = 0;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
        idle(30);
        check("burst5_rises", rises, QUEUE_EN ? 4 : 1);
        check("burst5_ovf", 32'(overflow_out), 1);
        check("burst5_pend", 32'(pending_out), 0);
        step(1'b0, 1'b0);

        // Event on the final GAP cycle chains straight into the next pulse
        rises = 0;
        step(1'b1, 1'b1);
        idle(H_CYC + L_CYC - 1);
        step(1'b1, 1'b1);
        check("gapend_busy", 32'(busy_out), 1);
        check("gapend_pulse", 32'(pulse_out), 1);
        idle(12);
        check("gapend_rises", rises, 2);
        check("gapend_ovf", 32'(overflow_out), 0);

        // Reset mid-pulse with a simultaneous event
        rises = 0;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        check("midrst_pulse", 32'(pulse_out), 0);
        check("midrst_busy", 32'(busy_out), 0);
        check("midrst_ovf", 32'(overflow_out), 0);
        idle(12);
        check("midrst_rises", rises, 1);

        // Random traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 99) < 30, $urandom_range(0, 99) != 0);
        end
        idle(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
